// File: rtl/dispatch_scoreboard_if.sv
// Handshake bundle between decoder, dispatch stage and execute/writeback.
// master = decoder/execute side, slave = dispatch_scoreboard.
interface dispatch_scoreboard_if #(
    parameter int INST_W = 32,
    parameter int OP_W   = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [OP_W-1:0]   in_op;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_rd;
    logic              in_use_rs1;
    logic              in_use_rs2;
    logic              in_we;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [OP_W-1:0]   out_op;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [4:0]        out_rd;
    logic              out_we;
    logic              wb_valid;
    logic [4:0]        wb_addr;
    logic              flush;

    modport master (
        output in_valid, in_inst, in_op, in_rs1, in_rs2, in_rd,
               in_use_rs1, in_use_rs2, in_we,
        input  in_ready,
        input  out_valid, out_inst, out_op, out_rs1, out_rs2, out_rd, out_we,
        output out_ready, wb_valid, wb_addr, flush
    );

    modport slave (
        input  in_valid, in_inst, in_op, in_rs1, in_rs2, in_rd,
               in_use_rs1, in_use_rs2, in_we,
        output in_ready,
        output out_valid, out_inst, out_op, out_rs1, out_rs2, out_rd, out_we,
        input  out_ready, wb_valid, wb_addr, flush
    );
endinterface

// File: rtl/dispatch_scoreboard.sv
// Single-entry dispatch stage with a register busy scoreboard (RAW/WAW interlock).
// Optional stall counter output enabled by DISPATCH_PERF_EN.
module dispatch_scoreboard #(
    parameter int INST_W = 32,
    parameter int OP_W   = 8,
    parameter int REG_N  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dispatch_scoreboard_if.slave bus,
`ifdef DISPATCH_PERF_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic [1:0]           state
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ISSUE = 2'b01,
        ST_STALL = 2'b10
    } state_t;

    logic              full_r;
    logic [INST_W-1:0] inst_r;
    logic [OP_W-1:0]   op_r;
    logic [4:0]        rs1_r;
    logic [4:0]        rs2_r;
    logic [4:0]        rd_r;
    logic              use_rs1_r;
    logic              use_rs2_r;
    logic              we_r;
    logic [REG_N-1:0]  busy_r;
    logic [REG_N-1:0]  busy_next_s;
    logic              hazard_s;
    logic              out_valid_s;
    logic              accept_s;
    logic              issue_s;
    state_t            state_s;

    // A register blocks the held entry when it is referenced, non-zero, busy and not retiring now.
    function automatic logic reg_blocked(input logic used, input logic [4:0] r,
                                         input logic [REG_N-1:0] busy,
                                         input logic wb_v, input logic [4:0] wb_a);
        return used && (r != 5'd0) && busy[r] && !(wb_v && (wb_a == r));
    endfunction

    assign hazard_s = full_r && (reg_blocked(use_rs1_r, rs1_r, busy_r, bus.wb_valid, bus.wb_addr) ||
                                 reg_blocked(use_rs2_r, rs2_r, busy_r, bus.wb_valid, bus.wb_addr) ||
                                 reg_blocked(we_r,      rd_r,  busy_r, bus.wb_valid, bus.wb_addr));
    assign out_valid_s  = full_r && !hazard_s;
    assign bus.in_ready = !bus.flush && (!full_r || (out_valid_s && bus.out_ready));
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign issue_s      = out_valid_s && bus.out_ready && !bus.flush;

    assign bus.out_valid = out_valid_s;
    assign bus.out_inst  = inst_r;
    assign bus.out_op    = op_r;
    assign bus.out_rs1   = rs1_r;
    assign bus.out_rs2   = rs2_r;
    assign bus.out_rd    = rd_r;
    assign bus.out_we    = we_r;
    assign state         = state_s;

    // Debug state follows the entry and the live hazard in the same cycle.
    always_comb begin
        state_s = ST_EMPTY;
        if (!full_r) begin
            state_s = ST_EMPTY;
        end else if (hazard_s) begin
            state_s = ST_STALL;
        end else begin
            state_s = ST_ISSUE;
        end
    end

    // Next scoreboard: retire first, then issue sets, so a collision leaves the bit set.
    always_comb begin
        busy_next_s = busy_r;
        if (bus.wb_valid && (bus.wb_addr != 5'd0)) begin
            busy_next_s[bus.wb_addr] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (issue_s && we_r && (rd_r != 5'd0)) begin
            busy_next_s[rd_r] = 1'b1;
        end else begin
            busy_next_s[0] = 1'b0;
        end
        busy_next_s[0] = 1'b0;
    end

    // Held entry: flush squashes, accept loads, issue invalidates, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r    <= 1'b0;
            inst_r    <= {INST_W{1'b0}};
            op_r      <= {OP_W{1'b0}};
            rs1_r     <= 5'd0;
            rs2_r     <= 5'd0;
            rd_r      <= 5'd0;
            use_rs1_r <= 1'b0;
            use_rs2_r <= 1'b0;
            we_r      <= 1'b0;
        end else if (bus.flush) begin
            full_r <= 1'b0;
        end else if (accept_s) begin
            full_r    <= 1'b1;
            inst_r    <= bus.in_inst;
            op_r      <= bus.in_op;
            rs1_r     <= bus.in_rs1;
            rs2_r     <= bus.in_rs2;
            rd_r      <= bus.in_rd;
            use_rs1_r <= bus.in_use_rs1;
            use_rs2_r <= bus.in_use_rs2;
            we_r      <= bus.in_we;
        end else if (issue_s) begin
            full_r <= 1'b0;
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {REG_N{1'b0}};
        end else if (bus.flush) begin
            busy_r <= {REG_N{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [31:0] stall_cnt_r;

    // Stall-cycle counter; survives flush and wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (state_s == ST_STALL) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_r;
`endif
endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_dispatch_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state;
`ifdef DISPATCH_PERF_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    dispatch_scoreboard_if #(.INST_W(32), .OP_W(8)) dif ();

    dispatch_scoreboard #(.INST_W(32), .OP_W(8), .REG_N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (dif),
`ifdef DISPATCH_PERF_EN
        .stall_cycles (stall_cycles),
`endif
        .state        (state)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        u1;
        logic        u2;
        logic        we;
    } ent_t;

    ent_t        m_ent;
    bit          m_full;
    logic [31:0] m_busy;
    logic [31:0] m_stalls;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // A register waits if it is used, not x0, pending, and not being retired right now.
    function automatic bit waits_on(input logic [4:0] r, input bit used);
        return used && (r != 5'd0) && m_busy[r] && !(dif.wb_valid && (dif.wb_addr == r));
    endfunction

    task automatic idle();
        dif.in_valid = 1'b0; dif.in_inst = 32'd0; dif.in_op = 8'd0;
        dif.in_rs1 = 5'd0; dif.in_rs2 = 5'd0; dif.in_rd = 5'd0;
        dif.in_use_rs1 = 1'b0; dif.in_use_rs2 = 1'b0; dif.in_we = 1'b0;
        dif.out_ready = 1'b1; dif.wb_valid = 1'b0; dif.wb_addr = 5'd0; dif.flush = 1'b0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit we);
        dif.in_valid = 1'b1; dif.in_inst = $urandom; dif.in_op = 8'($urandom);
        dif.in_rd = rd; dif.in_rs1 = rs1; dif.in_rs2 = rs2;
        dif.in_use_rs1 = u1; dif.in_use_rs2 = u2; dif.in_we = we;
    endtask

    // One clock: check all outputs at negedge against the model, then advance the model.
    task automatic cycle(input string tag);
        bit hz, ov, ir, acc, iss;
        logic [1:0] st;
        @(negedge clk);
        hz = m_full && (waits_on(m_ent.rs1, m_ent.u1) || waits_on(m_ent.rs2, m_ent.u2) ||
                        waits_on(m_ent.rd, m_ent.we));
        ov = m_full && !hz;
        ir = !dif.flush && (!m_full || (ov && dif.out_ready));
        st = !m_full ? 2'd0 : (hz ? 2'd2 : 2'd1);
        chk({tag, "/out_valid"}, 32'(dif.out_valid), 32'(ov));
        chk({tag, "/in_ready"},  32'(dif.in_ready),  32'(ir));
        chk({tag, "/state"},     32'(state),         32'(st));
        chk({tag, "/busy"},      dut.busy_r,         m_busy);
        chk({tag, "/out_inst"},  dif.out_inst,       m_ent.inst);
        chk({tag, "/out_op"},    32'(dif.out_op),    32'(m_ent.op));
        chk({tag, "/out_regs"},  {17'd0, dif.out_rs1, dif.out_rs2, dif.out_rd},
                                 {17'd0, m_ent.rs1, m_ent.rs2, m_ent.rd});
        chk({tag, "/out_we"},    32'(dif.out_we),    32'(m_ent.we));
`ifdef DISPATCH_PERF_EN
        chk({tag, "/stall_cycles"}, stall_cycles, m_stalls);
`endif
        acc = dif.in_valid && ir;
        iss = ov && dif.out_ready && !dif.flush;
        @(posedge clk);
        if (st == 2'd2) m_stalls = m_stalls + 32'd1;
        if (dif.flush) begin
            m_full = 1'b0;
            m_busy = 32'd0;
        end else begin
            if (dif.wb_valid && dif.wb_addr != 5'd0) m_busy[dif.wb_addr] = 1'b0;
            if (iss && m_ent.we && m_ent.rd != 5'd0) m_busy[m_ent.rd] = 1'b1;
            if (acc) begin
                m_ent = {dif.in_inst, dif.in_op, dif.in_rs1, dif.in_rs2, dif.in_rd,
                         dif.in_use_rs1, dif.in_use_rs2, dif.in_we};
                m_full = 1'b1;
            end else if (iss) begin
                m_full = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        m_full = 1'b0; m_ent = '0; m_busy = 32'd0; m_stalls = 32'd0;
        chk("rst/state", 32'(state), 32'd0);
        chk("rst/out_valid", 32'(dif.out_valid), 32'd0);
        chk("rst/busy", dut.busy_r, 32'd0);
        chk("rst/out_fields", {dif.out_inst ^ {dif.out_op, 9'd0, dif.out_rs1, dif.out_rs2, dif.out_rd}},
            32'd0);
`ifdef DISPATCH_PERF_EN
        chk("rst/stall_cycles", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // Back-to-back issue
        put(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1); cycle("t1_a");
        put(5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1); #1;
        chk("t1/first_valid", 32'(dif.out_valid), 32'd1);
        chk("t1/first_rd", 32'(dif.out_rd), 32'd1);
        cycle("t1_b");
        idle(); #1;
        chk("t1/second_valid", 32'(dif.out_valid), 32'd1);
        chk("t1/second_rd", 32'(dif.out_rd), 32'd4);
        cycle("t1_c");
        chk("t1/busy", dut.busy_r, 32'h12);

        // RAW stall released by same-cycle writeback
        dif.wb_valid = 1'b1; dif.wb_addr = 5'd4; cycle("t2_wb4");
        idle(); put(5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1); cycle("t2_ld");
        idle(); #1;
        chk("t2/stall_state", 32'(state), 32'd2);
        chk("t2/stall_valid", 32'(dif.out_valid), 32'd0);
        cycle("t2_st");
        dif.wb_valid = 1'b1; dif.wb_addr = 5'd1; #1;
        chk("t2/bypass_valid", 32'(dif.out_valid), 32'd1);
        cycle("t2_wb1");
        idle(); #1;
        chk("t2/busy", dut.busy_r, 32'h80);

        // WAW with simultaneous writeback and issue
        put(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle("t3_a");
        put(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle("t3_b");
        idle(); #1;
        chk("t3/waw_state", 32'(state), 32'd2);
        cycle("t3_st");
        dif.wb_valid = 1'b1; dif.wb_addr = 5'd3; #1;
        chk("t3/waw_valid", 32'(dif.out_valid), 32'd1);
        cycle("t3_wb");
        idle(); #1;
        chk("t3/busy", dut.busy_r, 32'h88);

        // Backpressure: held fields stable, next input waits
        put(5'd9, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1); dif.out_ready = 1'b0; cycle("t4_ld");
        put(5'd11, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4/in_ready_low", 32'(dif.in_ready), 32'd0);
            chk("t4/held_rd", 32'(dif.out_rd), 32'd9);
            cycle("t4_bp");
        end
        dif.out_ready = 1'b1; #1;
        chk("t4/in_ready_rise", 32'(dif.in_ready), 32'd1);
        cycle("t4_go");
        idle(); #1;
        chk("t4/new_rd", 32'(dif.out_rd), 32'd11);

        // Flush while stalled, with input and writeback also present
        chk("t5/pre_state", 32'(state), 32'd2);
        put(5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        dif.wb_valid = 1'b1; dif.wb_addr = 5'd3; dif.flush = 1'b1; #1;
        chk("t5/in_ready", 32'(dif.in_ready), 32'd0);
        cycle("t5_fl");
        idle(); #1;
        chk("t5/state", 32'(state), 32'd0);
        chk("t5/busy", dut.busy_r, 32'd0);
        cycle("t5_post");

        // Reset mid-operation, x0 destination, stall counting
        put(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle("t6_pre");
        do_reset();
        put(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle("t6_x0");
        idle(); cycle("t6_x0_iss");
        chk("t6/x0_busy", dut.busy_r, 32'd0);
        put(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cycle("t6_w5");
        put(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1); cycle("t6_r5");
        idle();
        for (int i = 0; i < 3; i++) cycle("t6_st");
`ifdef DISPATCH_PERF_EN
        chk("t6/stall_cycles", stall_cycles, 32'd3);
`endif
        dif.wb_valid = 1'b1; dif.wb_addr = 5'd5; cycle("t6_rel");
        do_reset();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 7)
                put(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom), 1'($urandom), 1'($urandom));
            else
                dif.in_valid = 1'b0;
            dif.out_ready = ($urandom_range(0, 3) != 0);
            dif.wb_valid  = ($urandom_range(0, 9) < 4);
            dif.wb_addr   = 5'($urandom_range(0, 7));
            dif.flush     = ($urandom_range(0, 99) < 3);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
